mux4x4bit8to1: RTL and testbench

- 16-bit, 8-to-1 data selector built from four 4-bit slices.
- Selects one of eight 16-bit words A0..A7 using a 3-bit select S2:S0.
- Output Y is registered.
- Sits on the read side of the eight-register register file and drives the read-data bus.

---
 rtl/mux4x4bit8to1_pkg.sv | 15 +
 rtl/mux4bit8to1.sv | 36 +++
 rtl/mux4x4bit8to1.sv | 72 +++++++
 tb/tb_mux4x4bit8to1.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4x4bit8to1_pkg.sv
// Shared widths, types and constants for the 16-bit 8-to-1 sliced read mux.
package mux4x4bit8to1_pkg;

    localparam int unsigned SLICE_W = 4;
    localparam int unsigned NSLICE  = 4;
    localparam int unsigned DATA_W  = SLICE_W * NSLICE;
    localparam int unsigned SEL_W   = 3;

    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [SEL_W-1:0]   sel_t;
    typedef logic [SLICE_W-1:0] slice_t;

    localparam data_t DATA_RST = DATA_W'(16'h0000);

endpackage

// File: rtl/mux4bit8to1.sv
// mux4bit8to1: combinational 4-bit, 8-to-1 selector (one slice of the read mux).
// Ports:
//   i_d0..i_d7 : eight slice-wide candidate words
//   i_sel      : 3-bit select, 0 picks i_d0, 7 picks i_d7
//   o_y_c      : selected word (combinational)
module mux4bit8to1
    import mux4x4bit8to1_pkg::*;
(
    input  logic [SLICE_W-1:0] i_d0,
    input  logic [SLICE_W-1:0] i_d1,
    input  logic [SLICE_W-1:0] i_d2,
    input  logic [SLICE_W-1:0] i_d3,
    input  logic [SLICE_W-1:0] i_d4,
    input  logic [SLICE_W-1:0] i_d5,
    input  logic [SLICE_W-1:0] i_d6,
    input  logic [SLICE_W-1:0] i_d7,
    input  logic [SEL_W-1:0]   i_sel,
    output logic [SLICE_W-1:0] o_y_c
);

    // All eight codes are decoded, so no X/default path exists.
    always_comb begin
        o_y_c = i_d0;
        case (i_sel)
            3'd0: o_y_c = i_d0;
            3'd1: o_y_c = i_d1;
            3'd2: o_y_c = i_d2;
            3'd3: o_y_c = i_d3;
            3'd4: o_y_c = i_d4;
            3'd5: o_y_c = i_d5;
            3'd6: o_y_c = i_d6;
            3'd7: o_y_c = i_d7;
        endcase
    end

endmodule

// File: rtl/mux4x4bit8to1.sv
// mux4x4bit8to1: 16-bit 8-to-1 registered read-data selector built from four
// 4-bit slices. Drives the register-file read-data bus.
// Optional build macro MUX4X4BIT8TO1_LOAD_EN adds an EN load-enable input.
// Ports:
//   CLK        : rising-edge clock
//   RST_N      : asynchronous active-low reset, clears Y
//   A0..A7     : 16-bit candidate words
//   S0,S1,S2   : select bits, index = {S2,S1,S0}
//   EN         : (macro only) load enable, 0 holds Y
//   Y          : registered selected word
module mux4x4bit8to1
    import mux4x4bit8to1_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] A0,
    input  logic [DATA_W-1:0] A1,
    input  logic [DATA_W-1:0] A2,
    input  logic [DATA_W-1:0] A3,
    input  logic [DATA_W-1:0] A4,
    input  logic [DATA_W-1:0] A5,
    input  logic [DATA_W-1:0] A6,
    input  logic [DATA_W-1:0] A7,
    input  logic              S0,
    input  logic              S1,
    input  logic              S2,
`ifdef MUX4X4BIT8TO1_LOAD_EN
    input  logic              EN,
`endif
    output logic [DATA_W-1:0] Y
);

    sel_t  w_sel;
    data_t w_next;
    data_t r_y;

    assign w_sel = {S2, S1, S0};

    // Each slice picks its own nibble of every word using the shared select.
    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        mux4bit8to1 u_slice (
            .i_d0  (A0[k*SLICE_W +: SLICE_W]),
            .i_d1  (A1[k*SLICE_W +: SLICE_W]),
            .i_d2  (A2[k*SLICE_W +: SLICE_W]),
            .i_d3  (A3[k*SLICE_W +: SLICE_W]),
            .i_d4  (A4[k*SLICE_W +: SLICE_W]),
            .i_d5  (A5[k*SLICE_W +: SLICE_W]),
            .i_d6  (A6[k*SLICE_W +: SLICE_W]),
            .i_d7  (A7[k*SLICE_W +: SLICE_W]),
            .i_sel (w_sel),
            .o_y_c (w_next[k*SLICE_W +: SLICE_W])
        );
    end

    // Output register; reset clears immediately regardless of clock or enable.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_y <= DATA_RST;
        end else begin
`ifdef MUX4X4BIT8TO1_LOAD_EN
            if (EN) begin
                r_y <= w_next;
            end
`else
            r_y <= w_next;
`endif
        end
    end

    assign Y = r_y;

endmodule

// File: tb/tb_mux4x4bit8to1.sv
// Directed self-checking bench for mux4x4bit8to1.
module tb_mux4x4bit8to1;

    logic        clk;
    logic        rst_n;
    logic [15:0] a [8];
    logic [2:0]  s;
    logic        en;
    logic [15:0] y;

    int checks;
    int failures;

    mux4x4bit8to1 dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .A0    (a[0]),
        .A1    (a[1]),
        .A2    (a[2]),
        .A3    (a[3]),
        .A4    (a[4]),
        .A5    (a[5]),
        .A6    (a[6]),
        .A7    (a[7]),
        .S0    (s[0]),
        .S1    (s[1]),
        .S2    (s[2]),
`ifdef MUX4X4BIT8TO1_LOAD_EN
        .EN    (en),
`endif
        .Y     (y)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic load_sweep_words();
        a[0] = 16'h0000; a[1] = 16'h0001; a[2] = 16'h0010; a[3] = 16'h0011;
        a[4] = 16'h0100; a[5] = 16'h0101; a[6] = 16'h0110; a[7] = 16'h0111;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s     = 3'd0;
        en    = 1'b1;
        for (int i = 0; i < 8; i++) a[i] = 16'h0000;
        #1;
        checks++;
        if (y !== 16'h0000) begin
            failures++;
            $display("FAIL reset_initial: Y=%h expected=%h", y, 16'h0000);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (y !== 16'h0000) begin
                failures++;
                $display("FAIL reset_held[%0d]: Y=%h expected=%h", i, y, 16'h0000);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (y !== 16'h0000) begin
            failures++;
            $display("FAIL reset_first_edge: Y=%h expected=%h", y, 16'h0000);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] exp_tab [8];
        exp_tab[0] = 16'h0000; exp_tab[1] = 16'h0001; exp_tab[2] = 16'h0010;
        exp_tab[3] = 16'h0011; exp_tab[4] = 16'h0100; exp_tab[5] = 16'h0101;
        exp_tab[6] = 16'h0110; exp_tab[7] = 16'h0111;
        load_sweep_words();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s = 3'(i);
            @(posedge clk); #1;
            checks++;
            if (y !== exp_tab[i]) begin
                failures++;
                $display("FAIL sweep_sel%0d: Y=%h expected=%h", i, y, exp_tab[i]);
            end
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        s = 3'd0;
        @(posedge clk); #1;
        checks++;
        if (y !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_7_to_0: Y=%h expected=%h", y, 16'h0000);
        end
    endtask

    task automatic test_slice_independence();
        for (int i = 0; i < 8; i++) a[i] = 16'hFFFF;
        a[5] = 16'hA5C3;
        @(negedge clk);
        s = 3'd5;
        @(posedge clk); #1;
        checks++;
        if (y !== 16'hA5C3) begin
            failures++;
            $display("FAIL slice_sel5: Y=%h expected=%h", y, 16'hA5C3);
        end
        @(negedge clk);
        s = 3'd4;
        @(posedge clk); #1;
        checks++;
        if (y !== 16'hFFFF) begin
            failures++;
            $display("FAIL slice_sel4: Y=%h expected=%h", y, 16'hFFFF);
        end
        // Select wiggles mid-cycle; only the value present at the edge counts.
        @(negedge clk);
        s = 3'd4;
        #4 s = 3'd5;
        @(posedge clk); #1;
        checks++;
        if (y !== 16'hA5C3) begin
            failures++;
            $display("FAIL slice_edge_sample: Y=%h expected=%h", y, 16'hA5C3);
        end
        // Between edges, a select change must not disturb Y.
        s = 3'd0;
        #3;
        checks++;
        if (y !== 16'hA5C3) begin
            failures++;
            $display("FAIL slice_hold_between_edges: Y=%h expected=%h", y, 16'hA5C3);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  seq [4];
        logic [15:0] exp_tab [4];
        seq[0] = 3'd6; seq[1] = 3'd1; seq[2] = 3'd4; seq[3] = 3'd3;
        exp_tab[0] = 16'h0110; exp_tab[1] = 16'h0001;
        exp_tab[2] = 16'h0100; exp_tab[3] = 16'h0011;
        load_sweep_words();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s = seq[i];
            @(posedge clk); #1;
            checks++;
            if (y !== exp_tab[i]) begin
                failures++;
                $display("FAIL b2b_step%0d: Y=%h expected=%h", i, y, exp_tab[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        load_sweep_words();
        @(negedge clk);
        s = 3'd7;
        @(posedge clk); #1;
        checks++;
        if (y !== 16'h0111) begin
            failures++;
            $display("FAIL async_pre: Y=%h expected=%h", y, 16'h0111);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (y !== 16'h0000) begin
            failures++;
            $display("FAIL async_clear: Y=%h expected=%h", y, 16'h0000);
        end
        #3 rst_n = 1'b1;
        #1;
        checks++;
        if (y !== 16'h0000) begin
            failures++;
            $display("FAIL async_released_before_edge: Y=%h expected=%h", y, 16'h0000);
        end
        @(posedge clk); #1;
        checks++;
        if (y !== 16'h0111) begin
            failures++;
            $display("FAIL async_reload: Y=%h expected=%h", y, 16'h0111);
        end
    endtask

`ifdef MUX4X4BIT8TO1_LOAD_EN
    task automatic test_load_en();
        load_sweep_words();
        @(negedge clk);
        en = 1'b1;
        s  = 3'd3;
        @(posedge clk); #1;
        checks++;
        if (y !== 16'h0011) begin
            failures++;
            $display("FAIL en_load: Y=%h expected=%h", y, 16'h0011);
        end
        @(negedge clk);
        en = 1'b0;
        s  = 3'd6;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (y !== 16'h0011) begin
                failures++;
                $display("FAIL en_hold[%0d]: Y=%h expected=%h", i, y, 16'h0011);
            end
        end
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (y !== 16'h0110) begin
            failures++;
            $display("FAIL en_resume: Y=%h expected=%h", y, 16'h0110);
        end
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (y !== 16'h0000) begin
            failures++;
            $display("FAIL en_reset_overrides: Y=%h expected=%h", y, 16'h0000);
        end
        #3 rst_n = 1'b1;
        en = 1'b1;
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_sweep();
        test_wrap();
        test_slice_independence();
        test_back_to_back();
        test_async_reset();
`ifdef MUX4X4BIT8TO1_LOAD_EN
        test_load_en();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
